pitch_meter: RTL and testbench
==============================

PITCH_METER -- requirements
Module: pitch_meter

Interface
REQ-001 SHALL have parameter PCM_W, default 16: width of signed PCM input sample.
REQ-002 SHALL have parameter SINE_W, default 8: phase width of the tone source, used to convert period to a divider value.
REQ-003 SHALL have parameter HYST, default 64: zero-crossing hysteresis threshold (positive, < 2^(PCM_W-1)).
REQ-004 SHALL have parameter AVG_LOG2, default 2: number of periods averaged per result is 2^AVG_LOG2.
REQ-005 SHALL have parameter TIMEOUT, default 24'hFFFFFF: maximum period count before loss of lock.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have ports: clr  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: x  in  PCM_W  signed PCM sample, one per clk.
REQ-009 SHALL have ports: per_out  out  24  averaged period in clk cycles.
REQ-010 SHALL have ports: cyc_out  out  16  divider value equivalent to per_out.
REQ-011 SHALL have ports: out_valid  out  1  result available; out_ready  in  1  consumer accepts.
REQ-012 SHALL have ports: lock  out  1  periodic input tracked; overrun  out  1  one-cycle pulse, unread result overwritten.

Function
REQ-013 SHALL keep input sign state UNK/LOW/HIGH: x <= -HYST -> LOW; x >= +HYST -> HIGH; otherwise hold.
REQ-014 SHALL generate a rising event only on a LOW->HIGH transition; UNK->HIGH SHALL NOT be an event.
REQ-015 SHALL run FSM SEEK/MEASURE; in SEEK, the first rising event loads cnt<=1, clears acc and nper, and enters MEASURE.
REQ-016 SHALL, in MEASURE, increment 24-bit cnt every cycle without an event; period = cnt value at the event cycle, which is the clk distance between consecutive events.
REQ-017 SHALL, on an event in MEASURE with nper < 2^AVG_LOG2-1: acc<=acc+cnt, nper<=nper+1, cnt<=1.
REQ-018 SHALL, on an event with nper = 2^AVG_LOG2-1: per_out<=(acc+cnt)>>AVG_LOG2 (truncate), acc<=0, nper<=0, cnt<=1, out_valid<=1, lock<=1; acc width 24+AVG_LOG2.
REQ-019 SHALL compute cyc_out combinationally from per_out: (per_out>>SINE_W)-1, saturating at 0 when per_out>>SINE_W is 0.
REQ-020 SHALL hold out_valid and per_out stable until out_valid&out_ready; out_valid clears the following cycle.
REQ-021 SHALL, when a new result is produced while out_valid=1 and out_ready=0, overwrite per_out, keep out_valid=1, and pulse overrun for one cycle.
REQ-022 SHALL give a new result priority over a same-cycle acceptance: out_valid stays 1 with the new value; no overrun in that case.
REQ-023 SHALL, when cnt reaches TIMEOUT in MEASURE with no event, go to SEEK, clear lock, acc, nper and sign state (UNK); a pending result SHALL remain valid.
REQ-024 SHALL treat an event in the same cycle as the timeout as an event (event wins).
REQ-025 SHALL, in SEEK, hold cnt at 0 and produce no results.

Reset
REQ-026 SHALL, while clr=1, asynchronously force FSM=SEEK, sign=UNK, cnt=0, acc=0, nper=0, per_out=0, out_valid=0, lock=0, overrun=0; cyc_out thus reads 0.
REQ-027 SHALL, when clr asserts mid-measurement, discard partial accumulation; the first result after release requires 1+2^AVG_LOG2 fresh events.

Verification
REQ-028 SHALL cover: square wave +/-1000, period 2560, defaults, out_ready=1 -> out_valid pulse 1 cycle after 5th rising event, per_out=2560, cyc_out=9, lock=1.
REQ-029 SHALL cover: alternating periods 2500/2620 x2 -> per_out=2560; periods 2561,2561,2561,2560 -> per_out=2560 (truncate).
REQ-030 SHALL cover: input noise within +/-63 only -> no event, lock=0, out_valid=0 indefinitely.
REQ-031 SHALL cover: TIMEOUT=5000, locked at 2560 then input held at +1000 -> lock=0 5000 cycles after last event, pending per_out still valid.
REQ-032 SHALL cover: out_ready=0 across two results -> overrun pulses once, per_out shows second value; then out_ready=1 -> out_valid drops next cycle.
REQ-033 SHALL cover: clr pulsed after 3 events -> all outputs 0 immediately (asynchronous); next result only after 5 new events.

Source files
------------

// File: rtl/pitch_meter.sv
// -----------------------------------------------------------------------------
// pitch_meter
//
// Measures the period of a PCM input in clk cycles and averages it over
// 2^AVG_LOG2 periods. The input passes through a hysteresis slicer
// (UNK/LOW/HIGH). Each LOW->HIGH transition is a rising event, and the
// spacing between consecutive events is one period. A SEEK/MEASURE FSM
// tracks lock. It drops back to SEEK when no event arrives within TIMEOUT
// cycles.
//
// Ports
//   clk        in   sole clock, rising edge
//   clr        in   asynchronous active-high reset
//   x          in   signed PCM sample, one per clk
//   per_out    out  averaged period in clk cycles
//   cyc_out    out  divider value: (per_out >> SINE_W) - 1, floored at 0
//   out_valid  out  result available (held until out_ready)
//   out_ready  in   consumer accepts the result
//   lock       out  periodic input is being tracked
//   overrun    out  one-cycle pulse: an unread result was overwritten
// -----------------------------------------------------------------------------
module pitch_meter #(
    parameter int          PCM_W    = 16,
    parameter int          SINE_W   = 8,
    parameter int          HYST     = 64,
    parameter int          AVG_LOG2 = 2,
    parameter logic [23:0] TIMEOUT  = 24'hFFFFFF
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic signed [PCM_W-1:0] x,
    output logic [23:0]             per_out,
    output logic [15:0]             cyc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    lock,
    output logic                    overrun
);

    localparam int ACC_W  = 24 + AVG_LOG2;
    localparam int NPER_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NPER_W-1:0]       NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);
    localparam logic signed [PCM_W-1:0] HYST_POS  = PCM_W'(HYST);
    localparam logic signed [PCM_W-1:0] HYST_NEG  = PCM_W'(-HYST);

    typedef enum logic [1:0] {SIGN_UNK, SIGN_LOW, SIGN_HIGH} sign_t;
    typedef enum logic       {ST_SEEK, ST_MEASURE}           state_t;

    state_t             r_state, w_state_nxt;
    sign_t              r_sign, w_sign_nxt;
    logic [23:0]        r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [NPER_W-1:0]  r_nper;
    logic [23:0]        r_per;
    logic               r_valid;
    logic               r_lock;
    logic               r_overrun;

    logic               w_event;
    logic               w_timeout;
    logic               w_last;
    logic               w_result;
    logic [ACC_W-1:0]   w_sum;
    logic [23:0]        w_div;

    // Slicer, event/timeout decode and FSM next state.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        w_sign_nxt  = r_sign;
        w_state_nxt = r_state;

        // Samples inside the hysteresis band hold the previous sign.
        if (x <= HYST_NEG) begin
            w_sign_nxt = SIGN_LOW;
        end else if (x >= HYST_POS) begin
            w_sign_nxt = SIGN_HIGH;
        end

        // UNK->HIGH is not an event. After reset or timeout, a full LOW
        // phase must be seen first.
        w_event   = (r_sign == SIGN_LOW) && (w_sign_nxt == SIGN_HIGH);
        // An event in the timeout cycle wins.
        w_timeout = (r_state == ST_MEASURE) && !w_event && (r_cnt == TIMEOUT);
        w_last    = (r_nper == NPER_LAST);
        w_result  = (r_state == ST_MEASURE) && w_event && w_last;
        w_sum     = r_acc + ACC_W'(r_cnt);

        case (r_state)
            ST_SEEK:    if (w_event)   w_state_nxt = ST_MEASURE;
            ST_MEASURE: if (w_timeout) w_state_nxt = ST_SEEK;
            default:                   w_state_nxt = ST_SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_SEEK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sign    <= SIGN_UNK;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_nper    <= '0;
            r_per     <= '0;
            r_valid   <= 1'b0;
            r_lock    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees the
            // pre-edge value of the others regardless of statement order.
            r_sign    <= w_timeout ? SIGN_UNK : w_sign_nxt;
            r_overrun <= 1'b0;

            // Period counter and accumulator. cnt is loaded with 1 at an
            // event, so at the next event it equals the distance between them.
            if (r_state == ST_SEEK) begin
                if (w_event) begin
                    r_cnt  <= 24'd1;
                    r_acc  <= '0;
                    r_nper <= '0;
                end else begin
                    r_cnt  <= '0;
                end
            end else if (w_event) begin
                r_cnt <= 24'd1;
                if (w_last) begin
                    r_acc  <= '0;
                    r_nper <= '0;
                    r_lock <= 1'b1;
                end else begin
                    r_acc  <= w_sum;
                    r_nper <= r_nper + NPER_W'(1);
                end
            end else if (w_timeout) begin
                r_cnt  <= '0;
                r_acc  <= '0;
                r_nper <= '0;
                r_lock <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 24'd1;
            end

            // Output handshake. A new result overrides a same-cycle accept.
            // A timeout leaves a pending result untouched.
            if (w_result) begin
                r_per     <= 24'(w_sum >> AVG_LOG2);
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !out_ready;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Divider equivalent of the period, floored at zero.
    assign w_div   = r_per >> SINE_W;
    assign cyc_out = (w_div == 24'd0) ? 16'd0 : 16'(w_div - 24'd1);

    assign per_out   = r_per;
    assign out_valid = r_valid;
    assign lock      = r_lock;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pitch_meter.sv
// -----------------------------------------------------------------------------
// tb_pitch_meter
//
// Drives square-ish waves built from segments (a high part followed by a low
// part), so each segment start is a rising event and the segment length is a
// period. The reference model works from event timestamps and a queue of
// measured periods. Each cycle it snapshots the expected
// valid/lock/overrun/per_out, and on every accepted result it pushes the
// expected value to a data queue. A monitor pops and compares both.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pitch_meter;

    localparam int PCM_W    = 16;
    localparam int SINE_W   = 8;
    localparam int HYST     = 64;
    localparam int AVG_LOG2 = 2;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int TMO      = 5000;

    logic                    clk = 1'b0;
    logic                    clr;
    logic signed [PCM_W-1:0] x;
    logic [23:0]             per_out;
    logic [15:0]             cyc_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    lock;
    logic                    overrun;

    pitch_meter #(
        .PCM_W   (PCM_W),
        .SINE_W  (SINE_W),
        .HYST    (HYST),
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT (24'(TMO))
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .x        (x),
        .per_out  (per_out),
        .cyc_out  (cyc_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lock     (lock),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        l;
        logic        o;
        logic [23:0] per;
    } status_t;

    status_t st_q[$];
    int      data_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random per cycle
    int      now = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_cyc(input int per);
        int d;
        d = per / (1 << SINE_W);
        return (d == 0) ? 0 : d - 1;
    endfunction

    // ---------------- reference model ----------------
    int  m_sgn;      // -1 low, +1 high, 0 unknown
    bit  m_meas;
    int  m_last;
    int  periods[$];
    bit  m_valid, m_lock, m_ovr;
    int  m_per;
    int  xv, m_sum, m_rv;
    bit  m_ev, m_res;

    task automatic model_reset();
        m_sgn = 0; m_meas = 0; m_last = 0; periods.delete();
        m_valid = 0; m_lock = 0; m_ovr = 0; m_per = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        now++;
        if (clr) begin
            model_reset();
            st_q.push_back({1'b0, 1'b0, 1'b0, 24'd0});
        end else begin
            st_q.push_back({m_valid, m_lock, m_ovr, 24'(m_per)});
            if (m_valid && out_ready) data_q.push_back(m_per);

            xv    = int'(x);
            m_ev  = (m_sgn == -1) && (xv >= HYST);
            m_res = 0;
            if (xv <= -HYST) m_sgn = -1;
            else if (xv >= HYST) m_sgn = 1;

            if (m_ev) begin
                if (!m_meas) begin
                    m_meas = 1;
                    periods.delete();
                end else begin
                    periods.push_back(now - m_last);
                    if (periods.size() == NAVG) begin
                        m_sum = 0;
                        foreach (periods[i]) m_sum += periods[i];
                        m_rv  = m_sum / NAVG;
                        m_res = 1;
                        m_lock = 1;
                        periods.delete();
                    end
                end
                m_last = now;
            end else if (m_meas && (now - m_last) == TMO) begin
                m_meas = 0;
                m_lock = 0;
                m_sgn  = 0;
                periods.delete();
            end

            m_ovr = 0;
            if (m_res) begin
                m_ovr   = m_valid && !out_ready;
                m_per   = m_rv;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    status_t exp_st;
    int      exp_d;

    always @(negedge clk) begin
        #1;
        if (st_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL status_queue@%0d: got empty queue, expected a snapshot", now);
        end else begin
            exp_st = st_q.pop_front();
            check($sformatf("status{valid,lock,overrun,per_out}@%0d", now),
                  32'({out_valid, lock, overrun, per_out}), 32'(exp_st));
        end
        if (out_valid && out_ready) begin
            if (data_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept@%0d: got per_out=%0d accepted, expected no result", now, per_out);
            end else begin
                exp_d = data_q.pop_front();
                check($sformatf("per_out@%0d", now), 32'(per_out), 32'(exp_d));
                check($sformatf("cyc_out@%0d", now), 32'(cyc_out), 32'(exp_cyc(exp_d)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int v);
        @(posedge clk);
        #1;
        x = PCM_W'(v);
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else               out_ready = (rdy_mode == 1);
    endtask

    task automatic hold(input int v, input int n);
        repeat (n) cyc(v);
    endtask

    task automatic seg(input int p);
        hold(1000, p / 2);
        hold(-1000, p - p / 2);
    endtask

    // Random amplitudes with occasional in-band noise, which must only hold state.
    task automatic rseg(input int p);
        int h, a;
        h = p / 2;
        for (int i = 0; i < p; i++) begin
            if (i != 0 && i != h && $urandom_range(0, 7) == 0) begin
                a = int'($urandom_range(0, 126)) - 63;
            end else begin
                a = int'($urandom_range(HYST, 30000));
                if (i >= h) a = -a;
            end
            cyc(a);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_per_out"},   32'(per_out),   32'd0);
        check({tag, "_cyc_out"},   32'(cyc_out),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_lock"},      32'(lock),      32'd0);
        check({tag, "_overrun"},   32'(overrun),   32'd0);
    endtask

    initial begin
        clr       = 1'b1;
        x         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        clr = 1'b0;

        // Noise inside the hysteresis band: never an event.
        for (int i = 0; i < 1500; i++) cyc(int'($urandom_range(0, 126)) - 63);
        check("noise_lock", 32'(lock), 32'd0);
        check("noise_out_valid", 32'(out_valid), 32'd0);

        // Steady 2560 square wave, then alternating and truncating averages.
        hold(-1000, 100);
        repeat (4) seg(2560);
        seg(2500); seg(2620); seg(2500); seg(2620);
        seg(2561); seg(2561); seg(2561); seg(2560);
        // Small periods: cyc_out floors at 0, then 512 -> 1.
        repeat (4) seg(200);
        repeat (4) seg(512);
        // A period equal to TIMEOUT: the event wins over the timeout.
        seg(5000); seg(1000); seg(1000); seg(1000);

        // Randomised periods with random out_ready.
        rdy_mode = 2;
        repeat (8) rseg(int'($urandom_range(100, 2000)));

        // Drain, then hold out_ready low across two results (one overrun).
        rdy_mode = 1;
        seg(1000);
        rdy_mode = 0;
        repeat (7) seg(1000);
        // Input stuck high: lock drops after TIMEOUT, result stays pending.
        hold(1000, 6000);
        rdy_mode = 1;
        hold(1000, 5);

        // clr after three events, then a fresh run of five events.
        hold(-1000, 50);
        repeat (3) seg(800);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check_zero("clr_async");
        @(posedge clk);
        #1;
        clr = 1'b0;
        hold(-1000, 50);
        repeat (5) seg(700);
        hold(1000, 20);
        hold(0, 10);

        check("data_queue_drained", 32'(data_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
